mul_seq_ctrl: RTL and testbench

MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

---
 rtl/mul_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mul_seq_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq_ctrl.sv
// Sequential shift-and-add multiplier controller. Each CALC cycle does one add
// on an external combinational adder, then shifts the {A,Q} pair right by one.
module mul_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  output logic               add_czero,
  input  logic [WIDTH-1:0]   add_sum,
  input  logic               add_cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             out_valid_q;

  logic [WIDTH-1:0] a_d;
  logic [WIDTH-1:0] q_d;
  logic [CW-1:0]    cnt_d;

  // Adder is driven only while calculating; carry-out re-enters as the new MSB of A.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (busy_q) begin
      add_a = a_q;
      add_b = q_q[0] ? m_q : '0;
    end else begin
      add_a = '0;
      add_b = '0;
    end
    {a_d, q_d} = {add_cout, add_sum, q_q[WIDTH-1:1]};
    cnt_d      = cnt_q - CW'(1);
  end

  assign add_czero = 1'b0;
  assign out       = {a_q, q_q};
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;

  // Control FSM, datapath registers and state-decoded handshake flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      m_q         <= '0;
      a_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            m_q        <= in1;
            q_q        <= in2;
            a_q        <= '0;
            cnt_q      <= CW'(WIDTH);
            state_q    <= S_CALC;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_CALC: begin
          a_q   <= a_d;
          q_q   <= q_d;
          cnt_q <= cnt_d;
          // Last iteration: the counter still reads 1 during this cycle.
          if (cnt_q == CW'(1)) begin
            state_q     <= S_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Directed bench for mul_seq_ctrl: an 8-bit and a 4-bit instance, each wired
// to a behavioural combinational adder standing in for the external CLA.
module tb_mul_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // 8-bit instance
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b1, bz8, cz8, co8;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0, aa8, ab8, as8;
  logic [15:0] o8;
  assign {co8, as8} = {1'b0, aa8} + {1'b0, ab8};

  mul_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in1(a8), .in2(b8),
    .out_valid(ov8), .out_ready(or8), .out(o8), .busy(bz8),
    .add_a(aa8), .add_b(ab8), .add_czero(cz8), .add_sum(as8), .add_cout(co8)
  );

  // 4-bit instance
  logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b1, bz4, cz4, co4;
  logic [3:0] a4 = 4'd0, b4 = 4'd0, aa4, ab4, as4;
  logic [7:0] o4;
  assign {co4, as4} = {1'b0, aa4} + {1'b0, ab4};

  mul_seq_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .in1(a4), .in2(b4),
    .out_valid(ov4), .out_ready(or4), .out(o4), .busy(bz4),
    .add_a(aa4), .add_b(ab4), .add_czero(cz4), .add_sum(as4), .add_cout(co4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one pair on dut8, require 8 busy cycles then DONE with the product.
  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [15:0] prod);
    chk({tag, "_ready"}, {31'd0, ir8}, 32'd1);
    iv8 = 1'b1; a8 = x; b8 = y;
    tick();
    iv8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk({tag, "_busy"}, {30'd0, bz8, ov8}, 32'd2);
      chk({tag, "_cz"}, {31'd0, cz8}, 32'd0);
      tick();
    end
    chk({tag, "_done"}, {29'd0, ov8, bz8, ir8}, 32'd4);
    chk({tag, "_out"}, {16'd0, o8}, {16'd0, prod});
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_flags8", {29'd0, ir8, ov8, bz8}, 32'd4);
    chk("rst_out8", {16'd0, o8}, 32'd0);
    chk("rst_add8", {15'd0, aa8, ab8, cz8}, 32'd0);
    chk("rst_flags4", {29'd0, ir4, ov4, bz4}, 32'd4);
    chk("rst_out4", {24'd0, o4}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_hold", {29'd0, ir8, ov8, bz8}, 32'd4);

    // 255*255, first CALC cycle drives A=0 and B=M because Q[0]=1
    or8 = 1'b1;
    iv8 = 1'b1; a8 = 8'd255; b8 = 8'd255;
    tick();
    iv8 = 1'b0;
    chk("ff_first_add", {16'd0, aa8, ab8}, 32'h0000_00FF);
    repeat (7) tick();
    chk("ff_last_calc", {30'd0, bz8, ov8}, 32'd2);
    tick();
    chk("ff_done", {30'd0, ov8, bz8}, 32'd2);
    chk("ff_out", {16'd0, o8}, 32'h0000_FE01);
    tick();
    chk("ff_idle", {29'd0, ir8, ov8, bz8}, 32'd4);
    chk("ff_idle_add", {16'd0, aa8, ab8}, 32'd0);

    // zero multiplicand keeps fixed latency
    op8("zero", 8'd0, 8'd173, 16'd0);
    tick();

    // backpressure: product held for 5 cycles
    or8 = 1'b0;
    op8("bp", 8'd13, 8'd11, 16'd143);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_flags", {29'd0, ir8, ov8, bz8}, 32'd2);
      chk("bp_hold_out", {16'd0, o8}, 32'd143);
    end
    or8 = 1'b1;
    tick();
    chk("bp_release", {29'd0, ir8, ov8, bz8}, 32'd4);

    // in-flight rejection: 7*9 held on the inputs during 3*5
    iv8 = 1'b1; a8 = 8'd3; b8 = 8'd5;
    tick();
    a8 = 8'd7; b8 = 8'd9;
    repeat (8) tick();
    chk("rej_done", {30'd0, ov8, bz8}, 32'd2);
    chk("rej_out", {16'd0, o8}, 32'd15);
    tick();
    chk("rej_idle", {29'd0, ir8, ov8, bz8}, 32'd4);
    tick();
    chk("rej_second_busy", {29'd0, ir8, ov8, bz8}, 32'd1);
    repeat (8) tick();
    iv8 = 1'b0;
    chk("rej_second_done", {31'd0, ov8}, 32'd1);
    chk("rej_second_out", {16'd0, o8}, 32'd63);
    tick();

    // reset during the 4th CALC cycle of 200*100
    iv8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    chk("mid_busy", {31'd0, bz8}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_flags", {29'd0, ir8, ov8, bz8}, 32'd4);
    chk("mid_rst_out", {16'd0, o8}, 32'd0);
    chk("mid_rst_add", {15'd0, aa8, ab8, cz8}, 32'd0);
    op8("after_rst", 8'd2, 8'd3, 16'd6);
    tick();

    // WIDTH=4: 15*15 after 4 CALC cycles
    iv4 = 1'b1; a4 = 4'd15; b4 = 4'd15;
    tick();
    iv4 = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("w4_busy", {30'd0, bz4, ov4}, 32'd2);
      chk("w4_cz", {31'd0, cz4}, 32'd0);
      tick();
    end
    chk("w4_done", {30'd0, ov4, bz4}, 32'd2);
    chk("w4_out", {24'd0, o4}, 32'd225);
    chk("w4_cz_done", {31'd0, cz4}, 32'd0);
    tick();
    chk("w4_idle", {29'd0, ir4, ov4, bz4}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
